// File: rtl/reg_stack.sv
// LIFO register stack with saturating pointer and sticky overflow/underflow flags.
// Push+pop on a non-empty stack replaces the top entry in one cycle.
module reg_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int PW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic [WIDTH-1:0] top,
  output logic [PW-1:0]    count,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             we;
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    sp_lo;
  logic [AW-1:0]    top_idx;
  logic             rep, wr, ovfc, rd, unfc;

  // low bits wrap to 0 at DEPTH, so sp_lo-1 still addresses the top when full
  assign sp_lo   = count_q[AW-1:0];
  assign top_idx = sp_lo - AW'(1);

  assign empty = (count_q == '0);
  assign full  = (count_q == PW'(DEPTH));
  assign top   = empty ? '0 : mem_q[top_idx];

  assign count     = count_q;
  assign data_out  = dout_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

  assign rep  = push &  pop & ~empty;
  assign wr   = push & ~full & ~rep;
  assign ovfc = push & ~pop & full;
  assign rd   = pop & ~push & ~empty;
  assign unfc = pop & ~push & empty;

  always_comb begin
    count_d = count_q;
    dout_d  = dout_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    we      = 1'b0;
    wr_idx  = sp_lo;
    unique case (1'b1)
      rep: begin
        dout_d = mem_q[top_idx];
        we     = 1'b1;
        wr_idx = top_idx;
      end
      wr: begin
        we      = 1'b1;
        count_d = count_q + PW'(1);
      end
      ovfc: ovf_d = 1'b1;
      rd: begin
        dout_d  = mem_q[top_idx];
        count_d = count_q - PW'(1);
      end
      unfc: unf_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      dout_q  <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      dout_q  <= dout_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && we)
      mem_q[wr_idx] <= data_in;
  end

endmodule

// File: tb/tb_reg_stack.sv
// Bench for reg_stack: directed plan steps then random traffic,
// all checked against a queue-based LIFO model.
module tb_reg_stack;

  localparam int WIDTH = 8;
  localparam int DEPTH = 8;
  localparam int PW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst, push, pop;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out, top;
  logic [PW-1:0]    count;
  logic             empty, full, overflow, underflow;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [WIDTH-1:0] m_q[$];
  logic [WIDTH-1:0] m_dout;
  logic             m_ovf, m_unf;

  always #5 clk = ~clk;

  reg_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .push(push), .pop(pop),
    .data_in(data_in), .data_out(data_out), .top(top),
    .count(count), .empty(empty), .full(full),
    .overflow(overflow), .underflow(underflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic r, input logic pu, input logic po,
                       input logic [WIDTH-1:0] d);
    if (r) begin
      m_q.delete();
      m_dout = '0;
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
    end else if (pu && po) begin
      if (m_q.size() > 0) begin
        m_dout = m_q[m_q.size()-1];
        m_q[m_q.size()-1] = d;
      end else begin
        m_q.push_back(d);
      end
    end else if (pu) begin
      if (m_q.size() == DEPTH) m_ovf = 1'b1;
      else m_q.push_back(d);
    end else if (po) begin
      if (m_q.size() == 0) m_unf = 1'b1;
      else m_dout = m_q.pop_back();
    end
  endtask

  task automatic check_all();
    logic [WIDTH-1:0] etop;
    etop = (m_q.size() > 0) ? m_q[m_q.size()-1] : '0;
    chk("count", 32'(count), 32'(m_q.size()));
    chk("empty", 32'(empty), 32'(m_q.size() == 0));
    chk("full", 32'(full), 32'(m_q.size() == DEPTH));
    chk("top", 32'(top), 32'(etop));
    chk("data_out", 32'(data_out), 32'(m_dout));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("underflow", 32'(underflow), 32'(m_unf));
  endtask

  task automatic step(input logic r, input logic pu, input logic po,
                      input logic [WIDTH-1:0] d);
    rst = r; push = pu; pop = po; data_in = d;
    @(posedge clk);
    model(r, pu, po, d);
    @(negedge clk);
    rst = 1'b0; push = 1'b0; pop = 1'b0;
    check_all();
  endtask

  initial begin
    m_dout = '0; m_ovf = 1'b0; m_unf = 1'b0;
    rst = 1'b1; push = 1'b1; pop = 1'b0; data_in = 8'h77;

    step(1'b1, 1'b1, 1'b0, 8'h77);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);

    for (int i = 1; i <= 8; i++) step(1'b0, 1'b1, 1'b0, 8'(i * 8'h11));
    chk("fill_top", 32'(top), 32'h88);
    chk("fill_full", 32'(full), 32'd1);

    step(1'b0, 1'b1, 1'b0, 8'h99);
    chk("ovf_top", 32'(top), 32'h88);
    chk("ovf_flag", 32'(overflow), 32'd1);

    step(1'b0, 1'b1, 1'b1, 8'hC3);
    step(1'b0, 1'b0, 1'b1, 8'h00);
    chk("rep_full_dout", 32'(data_out), 32'hC3);

    for (int i = 7; i >= 1; i--) begin
      step(1'b0, 1'b0, 1'b1, 8'h00);
      chk("drain_dout", 32'(data_out), 32'(i * 8'h11));
    end
    chk("drain_empty", 32'(empty), 32'd1);
    chk("ovf_sticky", 32'(overflow), 32'd1);

    step(1'b0, 1'b0, 1'b1, 8'h00);
    chk("unf_flag", 32'(underflow), 32'd1);
    chk("unf_dout", 32'(data_out), 32'h11);
    step(1'b0, 1'b1, 1'b0, 8'h5A);
    chk("unf_push_top", 32'(top), 32'h5A);

    step(1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 1'b0, 8'h10);
    step(1'b0, 1'b1, 1'b0, 8'h20);
    step(1'b0, 1'b1, 1'b1, 8'h30);
    chk("rep_dout", 32'(data_out), 32'h20);
    chk("rep_top", 32'(top), 32'h30);
    chk("rep_count", 32'(count), 32'd2);

    step(1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 1'b1, 8'h44);
    chk("pp_empty_top", 32'(top), 32'h44);
    chk("pp_empty_unf", 32'(underflow), 32'd0);

    step(1'b0, 1'b1, 1'b0, 8'h01);
    step(1'b0, 1'b1, 1'b0, 8'h02);
    step(1'b1, 1'b0, 1'b1, 8'h00);
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_dout", 32'(data_out), 32'd0);
    step(1'b0, 1'b1, 1'b0, 8'hAB);
    step(1'b0, 1'b0, 1'b1, 8'h00);
    chk("midrst_pop", 32'(data_out), 32'hAB);

    for (int i = 0; i < 400; i++) begin
      logic r, pu, po;
      int k;
      k  = int'($urandom_range(0, 99));
      r  = ($urandom_range(0, 59) == 0);
      pu = (k < 60);
      po = (k >= 35 && k < 95) || (k < 10);
      if ((i / 40) % 2 == 1) begin
        pu = (k < 35);
        po = (k >= 20);
      end
      step(r, pu, po, 8'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
